// File: rtl/axi_lite_pkg.sv
// Shared constants, state encodings and address decode for the AXI-Lite register slave.
package axi_lite_pkg;

    localparam int         NUM_REGS_DEF = 4;
    localparam logic [1:0] RESP_OKAY    = 2'b00;
    localparam logic [1:0] RESP_SLVERR  = 2'b10;

    typedef enum logic {W_IDLE, W_RESP} wstate_e;
    typedef enum logic {R_IDLE, R_DATA} rstate_e;

    // Word-granular compare so byte lanes ADDR[1:0] never affect the decode.
    function automatic logic addr_in_range(input logic [31:0] addr, input int n);
        return (addr >> 2) < 32'(n);
    endfunction

endpackage

// File: rtl/axi_lite_regfile.sv
// Register array: one byte-enabled write port, one asynchronous read port.
module axi_lite_regfile
    import axi_lite_pkg::*;
#(
    parameter int NUM_REGS = NUM_REGS_DEF,
    parameter int IDX_W    = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             we_i,
    input  logic [IDX_W-1:0] widx_i,
    input  logic [31:0]      wdata_i,
    input  logic [3:0]       wstrb_i,
    input  logic [IDX_W-1:0] ridx_i,
    output logic [31:0]      rdata_o
);

    logic [31:0] regs_q [NUM_REGS];

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= '0;
        end else if (we_i) begin
            for (int k = 0; k < 4; k++)
                if (wstrb_i[k]) regs_q[widx_i][8*k +: 8] <= wdata_i[8*k +: 8];
        end
    end

    assign rdata_o = regs_q[ridx_i];

endmodule

// File: rtl/axi_lite_slave.sv
// AXI4-Lite slave exposing NUM_REGS 32-bit registers; independent AW/W capture, concurrent read path.
module axi_lite_slave
    import axi_lite_pkg::*;
#(
    parameter int NUM_REGS = NUM_REGS_DEF
) (
    input  logic        ACLK,
    input  logic        ARESETN,
    input  logic [31:0] S_AXI_AWADDR,
    input  logic        S_AXI_AWVALID,
    output logic        S_AXI_AWREADY,
    input  logic [31:0] S_AXI_WDATA,
    input  logic [3:0]  S_AXI_WSTRB,
    input  logic        S_AXI_WVALID,
    output logic        S_AXI_WREADY,
    output logic [1:0]  S_AXI_BRESP,
    output logic        S_AXI_BVALID,
    input  logic        S_AXI_BREADY,
    input  logic [31:0] S_AXI_ARADDR,
    input  logic        S_AXI_ARVALID,
    output logic        S_AXI_ARREADY,
    output logic [31:0] S_AXI_RDATA,
    output logic [1:0]  S_AXI_RRESP,
    output logic        S_AXI_RVALID,
    input  logic        S_AXI_RREADY
);

    localparam int IDX_W = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;

    wstate_e     w_state_q;
    rstate_e     r_state_q;
    logic        awready_q, wready_q, arready_q;
    logic        aw_lat_q, w_lat_q;
    logic [31:0] awaddr_q, wdata_q;
    logic [3:0]  wstrb_q;
    logic [1:0]  bresp_q, rresp_q;
    logic [31:0] rdata_q;
    logic [31:0] rf_rdata;
    logic        wr_fire, wr_en;

    assign wr_fire = (w_state_q == W_IDLE) && aw_lat_q && w_lat_q;
    assign wr_en   = wr_fire && addr_in_range(awaddr_q, NUM_REGS);

    axi_lite_regfile #(.NUM_REGS(NUM_REGS), .IDX_W(IDX_W)) u_regfile (
        .clk_i   (ACLK),
        .rst_ni  (ARESETN),
        .we_i    (wr_en),
        .widx_i  (awaddr_q[IDX_W+1:2]),
        .wdata_i (wdata_q),
        .wstrb_i (wstrb_q),
        .ridx_i  (S_AXI_ARADDR[IDX_W+1:2]),
        .rdata_o (rf_rdata)
    );

    // Ready pulses are self-clearing: the handshake edge also sets the latch that blocks them.
    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            w_state_q <= W_IDLE;
            awready_q <= 1'b0;
            wready_q  <= 1'b0;
            aw_lat_q  <= 1'b0;
            w_lat_q   <= 1'b0;
            awaddr_q  <= '0;
            wdata_q   <= '0;
            wstrb_q   <= '0;
            bresp_q   <= RESP_OKAY;
        end else begin
            awready_q <= S_AXI_AWVALID && !aw_lat_q && !awready_q && (w_state_q == W_IDLE);
            wready_q  <= S_AXI_WVALID  && !w_lat_q  && !wready_q  && (w_state_q == W_IDLE);
            if (awready_q && S_AXI_AWVALID) begin
                aw_lat_q <= 1'b1;
                awaddr_q <= S_AXI_AWADDR;
            end
            if (wready_q && S_AXI_WVALID) begin
                w_lat_q <= 1'b1;
                wdata_q <= S_AXI_WDATA;
                wstrb_q <= S_AXI_WSTRB;
            end
            case (w_state_q)
                W_IDLE: if (wr_fire) begin
                    w_state_q <= W_RESP;
                    bresp_q   <= wr_en ? RESP_OKAY : RESP_SLVERR;
                    aw_lat_q  <= 1'b0;
                    w_lat_q   <= 1'b0;
                end
                W_RESP: if (S_AXI_BREADY) w_state_q <= W_IDLE;
                default: w_state_q <= W_IDLE;
            endcase
        end
    end

    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            r_state_q <= R_IDLE;
            arready_q <= 1'b0;
            rdata_q   <= '0;
            rresp_q   <= RESP_OKAY;
        end else begin
            arready_q <= S_AXI_ARVALID && (r_state_q == R_IDLE) && !arready_q;
            case (r_state_q)
                R_IDLE: if (arready_q && S_AXI_ARVALID) begin
                    r_state_q <= R_DATA;
                    if (addr_in_range(S_AXI_ARADDR, NUM_REGS)) begin
                        rdata_q <= rf_rdata;
                        rresp_q <= RESP_OKAY;
                    end else begin
                        rdata_q <= '0;
                        rresp_q <= RESP_SLVERR;
                    end
                end
                R_DATA: if (S_AXI_RREADY) r_state_q <= R_IDLE;
                default: r_state_q <= R_IDLE;
            endcase
        end
    end

    assign S_AXI_AWREADY = awready_q;
    assign S_AXI_WREADY  = wready_q;
    assign S_AXI_BVALID  = (w_state_q == W_RESP);
    assign S_AXI_BRESP   = bresp_q;
    assign S_AXI_ARREADY = arready_q;
    assign S_AXI_RVALID  = (r_state_q == R_DATA);
    assign S_AXI_RDATA   = rdata_q;
    assign S_AXI_RRESP   = rresp_q;

endmodule

// File: tb/tb_axi_lite_slave.sv
// Directed plus randomized bench for axi_lite_slave against an array-based register model.
module tb_axi_lite_slave;

    localparam int NREG = 4;

    logic        ACLK = 1'b0;
    logic        ARESETN = 1'b0;
    logic [31:0] S_AXI_AWADDR = '0;
    logic        S_AXI_AWVALID = 1'b0;
    logic        S_AXI_AWREADY;
    logic [31:0] S_AXI_WDATA = '0;
    logic [3:0]  S_AXI_WSTRB = '0;
    logic        S_AXI_WVALID = 1'b0;
    logic        S_AXI_WREADY;
    logic [1:0]  S_AXI_BRESP;
    logic        S_AXI_BVALID;
    logic        S_AXI_BREADY = 1'b0;
    logic [31:0] S_AXI_ARADDR = '0;
    logic        S_AXI_ARVALID = 1'b0;
    logic        S_AXI_ARREADY;
    logic [31:0] S_AXI_RDATA;
    logic [1:0]  S_AXI_RRESP;
    logic        S_AXI_RVALID;
    logic        S_AXI_RREADY = 1'b0;

    int passed = 0;
    int fails  = 0;
    int total  = 0;

    logic [31:0] model [NREG];

    axi_lite_slave #(.NUM_REGS(NREG)) dut (
        .ACLK(ACLK), .ARESETN(ARESETN),
        .S_AXI_AWADDR(S_AXI_AWADDR), .S_AXI_AWVALID(S_AXI_AWVALID), .S_AXI_AWREADY(S_AXI_AWREADY),
        .S_AXI_WDATA(S_AXI_WDATA), .S_AXI_WSTRB(S_AXI_WSTRB), .S_AXI_WVALID(S_AXI_WVALID),
        .S_AXI_WREADY(S_AXI_WREADY), .S_AXI_BRESP(S_AXI_BRESP), .S_AXI_BVALID(S_AXI_BVALID),
        .S_AXI_BREADY(S_AXI_BREADY), .S_AXI_ARADDR(S_AXI_ARADDR), .S_AXI_ARVALID(S_AXI_ARVALID),
        .S_AXI_ARREADY(S_AXI_ARREADY), .S_AXI_RDATA(S_AXI_RDATA), .S_AXI_RRESP(S_AXI_RRESP),
        .S_AXI_RVALID(S_AXI_RVALID), .S_AXI_RREADY(S_AXI_RREADY)
    );

    always #5 ACLK = ~ACLK;

    initial begin
        #2000000;
        $error("FAIL watchdog: observed no finish, expected finish before 2ms");
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            fails++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Model: byte-addressed map of NREG words; anything at or beyond 4*NREG is an error slot.
    function automatic logic [31:0] m_read(input logic [31:0] addr);
        if (addr < 4 * NREG) return model[addr / 4];
        return 32'h0;
    endfunction

    function automatic logic [1:0] m_resp(input logic [31:0] addr);
        return (addr < 4 * NREG) ? 2'b00 : 2'b10;
    endfunction

    task automatic m_write(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb);
        if (addr < 4 * NREG)
            for (int k = 0; k < 4; k++)
                if (strb[k]) model[addr / 4][8*k +: 8] = data[8*k +: 8];
    endtask

    // One clock: entered and left at a falling edge; valids whose handshake completes are dropped.
    task automatic tick();
        logic ha, hw, hr;
        ha = S_AXI_AWVALID && S_AXI_AWREADY;
        hw = S_AXI_WVALID  && S_AXI_WREADY;
        hr = S_AXI_ARVALID && S_AXI_ARREADY;
        @(posedge ACLK);
        #1;
        if (ha) S_AXI_AWVALID = 1'b0;
        if (hw) S_AXI_WVALID  = 1'b0;
        if (hr) S_AXI_ARVALID = 1'b0;
        @(negedge ACLK);
    endtask

    task automatic axi_write(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb,
                             input int lead, output logic [1:0] resp, output int aw_cyc, output int w_cyc);
        int n;
        bit w_on;
        S_AXI_AWADDR = addr; S_AXI_WDATA = data; S_AXI_WSTRB = strb;
        S_AXI_AWVALID = 1'b1;
        w_on = 0; n = 0; aw_cyc = -1; w_cyc = -1;
        while (n < 40 && (S_AXI_AWVALID || S_AXI_WVALID || !w_on)) begin
            if (!w_on && n >= lead) begin S_AXI_WVALID = 1'b1; w_on = 1; end
            if (S_AXI_AWREADY && aw_cyc < 0) aw_cyc = n;
            if (S_AXI_WREADY && w_cyc < 0) w_cyc = n;
            tick();
            n++;
        end
        chk("wr_handshake", {30'b0, S_AXI_AWVALID, S_AXI_WVALID}, 32'h0);
        S_AXI_AWVALID = 1'b0; S_AXI_WVALID = 1'b0;
        n = 0;
        while (!S_AXI_BVALID && n < 40) begin tick(); n++; end
        chk("bvalid", S_AXI_BVALID, 1);
        resp = S_AXI_BRESP;
        S_AXI_BREADY = 1'b1; tick(); S_AXI_BREADY = 1'b0;
    endtask

    task automatic axi_read(input logic [31:0] addr, output logic [31:0] data, output logic [1:0] resp);
        int n;
        S_AXI_ARADDR = addr; S_AXI_ARVALID = 1'b1; n = 0;
        while (S_AXI_ARVALID && n < 40) begin tick(); n++; end
        chk("rd_handshake", S_AXI_ARVALID, 0);
        S_AXI_ARVALID = 1'b0;
        n = 0;
        while (!S_AXI_RVALID && n < 40) begin tick(); n++; end
        chk("rvalid", S_AXI_RVALID, 1);
        data = S_AXI_RDATA; resp = S_AXI_RRESP;
        S_AXI_RREADY = 1'b1; tick(); S_AXI_RREADY = 1'b0;
    endtask

    initial begin
        logic [31:0] rd, a, d, r0;
        logic [1:0]  rr, br, b0;
        logic [3:0]  s;
        int ac, wc, n;

        for (int i = 0; i < NREG; i++) model[i] = '0;
        repeat (3) @(negedge ACLK);
        chk("reset_outputs", {S_AXI_AWREADY, S_AXI_WREADY, S_AXI_BVALID, S_AXI_ARREADY, S_AXI_RVALID,
                              S_AXI_BRESP, S_AXI_RRESP}, 32'h0);
        chk("reset_rdata", S_AXI_RDATA, 32'h0);
        ARESETN = 1'b1;

        for (int i = 0; i < NREG; i++) begin
            axi_read(4 * i, rd, rr);
            chk("reset_read_data", rd, 32'h0);
            chk("reset_read_resp", rr, 2'b00);
        end

        for (int i = 0; i < NREG; i++) begin
            axi_write(4 * i, 32'h1000_0000 + i, 4'hF, 0, br, ac, wc);
            m_write(4 * i, 32'h1000_0000 + i, 4'hF);
            chk("wr_bresp", br, 2'b00);
            chk("aw_w_same_cycle", ac, wc);
            axi_read(4 * i, rd, rr);
            chk("wr_readback", rd, 32'h1000_0000 + i);
        end
        for (int i = 0; i < NREG; i++) begin
            axi_read(4 * i, rd, rr);
            chk("regfile_contents", rd, 32'h1000_0000 + i);
        end

        axi_write(32'h8, 32'hAABB_CCDD, 4'b0011, 0, br, ac, wc);
        m_write(32'h8, 32'hAABB_CCDD, 4'b0011);
        axi_read(32'h8, rd, rr);
        chk("strb_partial", rd, 32'h1000_CCDD);

        axi_write(32'h10, 32'hDEAD_BEEF, 4'hF, 0, br, ac, wc);
        chk("oor_bresp", br, 2'b10);
        for (int i = 0; i < NREG; i++) begin
            axi_read(4 * i, rd, rr);
            chk("oor_unchanged", rd, m_read(4 * i));
        end
        axi_read(32'h10, rd, rr);
        chk("oor_rresp", rr, 2'b10);
        chk("oor_rdata", rd, 32'h0);

        // Both responses parked with ready low; a new AW must not be taken meanwhile.
        S_AXI_AWADDR = 32'h0; S_AXI_WDATA = 32'h0BAD_F00D; S_AXI_WSTRB = 4'hF;
        S_AXI_AWVALID = 1'b1; S_AXI_WVALID = 1'b1;
        S_AXI_ARADDR = 32'h4; S_AXI_ARVALID = 1'b1;
        n = 0;
        while (n < 40 && !(S_AXI_BVALID && S_AXI_RVALID)) begin tick(); n++; end
        chk("hold_setup", {S_AXI_BVALID, S_AXI_RVALID}, 2'b11);
        b0 = S_AXI_BRESP; r0 = S_AXI_RDATA;
        chk("hold_bresp0", b0, 2'b00);
        chk("hold_rdata0", r0, m_read(32'h4));
        S_AXI_AWADDR = 32'h8; S_AXI_AWVALID = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("hold_valids", {S_AXI_BVALID, S_AXI_RVALID}, 2'b11);
            chk("hold_bresp", S_AXI_BRESP, b0);
            chk("hold_rdata", S_AXI_RDATA, r0);
            chk("hold_no_awready", S_AXI_AWREADY, 0);
        end
        S_AXI_AWVALID = 1'b0; S_AXI_BREADY = 1'b1; S_AXI_RREADY = 1'b1;
        tick();
        S_AXI_BREADY = 1'b0; S_AXI_RREADY = 1'b0;
        m_write(32'h0, 32'h0BAD_F00D, 4'hF);
        axi_read(32'h0, rd, rr);
        chk("hold_write_landed", rd, m_read(32'h0));

        axi_write(32'h4, 32'h55, 4'hF, 3, br, ac, wc);
        m_write(32'h4, 32'h55, 4'hF);
        chk("aw_before_w", {31'b0, (ac >= 0) && (ac < wc)}, 1);
        axi_read(32'h4, rd, rr);
        chk("aw_lead_readback", rd, 32'h55);

        for (int t = 0; t < 24; t++) begin
            a = $urandom_range(0, 4 * NREG + 3);
            if ($urandom_range(0, 7) == 0) a = $urandom;
            d = $urandom;
            s = 4'($urandom_range(0, 15));
            axi_write(a, d, s, $urandom_range(0, 3), br, ac, wc);
            chk("rand_bresp", br, m_resp(a));
            m_write(a, d, s);
            a = $urandom_range(0, 4 * NREG + 3);
            axi_read(a, rd, rr);
            chk("rand_rdata", rd, m_read(a));
            chk("rand_rresp", rr, m_resp(a));
        end

        // Reset with address and data latched but the register write not yet performed.
        S_AXI_AWADDR = 32'hC; S_AXI_WDATA = 32'hFFFF_FFFF; S_AXI_WSTRB = 4'hF;
        S_AXI_AWVALID = 1'b1; S_AXI_WVALID = 1'b1;
        tick(); tick();
        ARESETN = 1'b0;
        #1;
        chk("midreset_outputs", {S_AXI_AWREADY, S_AXI_WREADY, S_AXI_BVALID, S_AXI_ARREADY,
                                 S_AXI_RVALID, S_AXI_BRESP, S_AXI_RRESP}, 32'h0);
        S_AXI_AWVALID = 1'b0; S_AXI_WVALID = 1'b0;
        @(negedge ACLK);
        ARESETN = 1'b1;
        for (int i = 0; i < NREG; i++) model[i] = '0;
        for (int i = 0; i < NREG; i++) begin
            axi_read(4 * i, rd, rr);
            chk("midreset_regs", rd, m_read(4 * i));
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
